// File: rtl/reg_arb_pkg.sv
// ============================================================================
// reg_arb_pkg : shared FSM state encoding and default widths for reg_arbiter
// Revision    : 1.0
// ============================================================================
`default_nettype none

package reg_arb_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    BUS  = 2'd1,
    DONE = 2'd2
  } arb_state_t;

  localparam int DEF_NUM_REQ        = 4;
  localparam int DEF_ADDR_WIDTH     = 8;
  localparam int DEF_DATA_WIDTH     = 16;
  localparam int DEF_TIMEOUT_CYCLES = 64;

endpackage

`default_nettype wire

// File: rtl/rr_pick.sv
// ============================================================================
// rr_pick  : combinational round-robin selector; lowest index at/after ptr wins
// Revision : 1.0
// ============================================================================
`default_nettype none

module rr_pick #(
  parameter int NUM_REQ = 4,
  parameter int PW      = 2
) (
  input  logic [NUM_REQ-1:0] req,
  input  logic [PW-1:0]      ptr,
  output logic [NUM_REQ-1:0] gnt,
  output logic [PW-1:0]      idx,
  output logic               valid
);

  logic [PW:0] w_cand;

  // Walk offsets from farthest to nearest so the nearest hit overwrites last.
  always_comb begin
    w_cand = '0;
    idx    = '0;
    valid  = 1'b0;
    for (int k = NUM_REQ - 1; k >= 0; k--) begin
      w_cand = {1'b0, ptr} + (PW+1)'(k);
      if (w_cand >= (PW+1)'(NUM_REQ)) begin
        w_cand = w_cand - (PW+1)'(NUM_REQ);
      end
      if (req[w_cand[PW-1:0]]) begin
        valid = 1'b1;
        idx   = w_cand[PW-1:0];
      end
    end
    gnt = valid ? (NUM_REQ'(1) << idx) : '0;
  end

endmodule

`default_nettype wire

// File: rtl/reg_arbiter.sv
// ============================================================================
// reg_arbiter : round-robin sharing of one reg_ctrl port among NUM_REQ agents;
//               optional bus watchdog enabled by macro REG_ARB_TIMEOUT_EN
// Revision    : 1.0
// ============================================================================
`default_nettype none

module reg_arbiter
  import reg_arb_pkg::*;
#(
  parameter int NUM_REQ        = DEF_NUM_REQ,
  parameter int ADDR_WIDTH     = DEF_ADDR_WIDTH,
  parameter int DATA_WIDTH     = DEF_DATA_WIDTH,
  parameter int TIMEOUT_CYCLES = DEF_TIMEOUT_CYCLES
) (
  input  logic                         clk,
  input  logic                         rstn,
  input  logic [NUM_REQ-1:0]           req,
  input  logic [NUM_REQ-1:0]           req_wr,
  input  logic [NUM_REQ*ADDR_WIDTH-1:0] req_addr,
  input  logic [NUM_REQ*DATA_WIDTH-1:0] req_wdata,
  output logic [NUM_REQ-1:0]           gnt,
  output logic [NUM_REQ-1:0]           done,
  output logic [DATA_WIDTH-1:0]        rdata,
  output logic                         err,
  output logic [ADDR_WIDTH-1:0]        m_addr,
  output logic [DATA_WIDTH-1:0]        m_wdata,
  output logic                         m_sel,
  output logic                         m_wr,
  input  logic [DATA_WIDTH-1:0]        m_rdata,
  input  logic                         m_ready
);

  localparam int PW = $clog2(NUM_REQ);

  arb_state_t r_state, w_state_nxt;

  logic [PW-1:0]         r_ptr, r_idx, w_ptr_nxt, w_pick_idx;
  logic [NUM_REQ-1:0]    w_pick_gnt, r_gnt, r_done;
  logic                  w_pick_valid;
  logic [ADDR_WIDTH-1:0] w_sel_addr, r_addr;
  logic [DATA_WIDTH-1:0] w_sel_wdata, r_wdata, r_rdata;
  logic                  w_sel_wr, r_wr, r_sel;
  logic                  w_timeout, w_complete;

  rr_pick #(
    .NUM_REQ (NUM_REQ),
    .PW      (PW)
  ) u_pick (
    .req   (req),
    .ptr   (r_ptr),
    .gnt   (w_pick_gnt),
    .idx   (w_pick_idx),
    .valid (w_pick_valid)
  );

  always_comb begin
    w_sel_addr  = '0;
    w_sel_wdata = '0;
    w_sel_wr    = 1'b0;
    for (int i = 0; i < NUM_REQ; i++) begin
      if (w_pick_gnt[i]) begin
        w_sel_addr  = req_addr[i*ADDR_WIDTH +: ADDR_WIDTH];
        w_sel_wdata = req_wdata[i*DATA_WIDTH +: DATA_WIDTH];
        w_sel_wr    = req_wr[i];
      end
    end
  end

`ifdef REG_ARB_TIMEOUT_EN
  localparam int TW = $clog2(TIMEOUT_CYCLES + 1);

  logic [TW-1:0] r_tcnt;
  logic          r_err;

  // Counter sits at zero outside BUS, so every BUS entry starts from zero.
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      r_tcnt <= '0;
    end else if (r_state != BUS) begin
      r_tcnt <= '0;
    end else if (!m_ready) begin
      r_tcnt <= r_tcnt + 1'b1;
    end
  end

  assign w_timeout = (r_state == BUS) && !m_ready &&
                     (r_tcnt == TW'(TIMEOUT_CYCLES - 1));

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      r_err <= 1'b0;
    end else begin
      r_err <= w_timeout;
    end
  end

  assign err = r_err;
`else
  assign w_timeout = 1'b0;
  assign err       = 1'b0;
`endif

  assign w_complete = (r_state == BUS) && (m_ready || w_timeout);
  assign w_ptr_nxt  = (r_idx == PW'(NUM_REQ - 1)) ? '0 : r_idx + 1'b1;

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      r_state <= IDLE;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      IDLE:    if (w_pick_valid) w_state_nxt = BUS;
      BUS:     if (w_complete)   w_state_nxt = DONE;
      DONE:    w_state_nxt = IDLE;
      default: w_state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      r_ptr   <= '0;
      r_idx   <= '0;
      r_gnt   <= '0;
      r_done  <= '0;
      r_addr  <= '0;
      r_wdata <= '0;
      r_wr    <= 1'b0;
      r_sel   <= 1'b0;
      r_rdata <= '0;
    end else begin
      r_done <= '0;
      case (r_state)
        IDLE: begin
          if (w_pick_valid) begin
            r_gnt   <= w_pick_gnt;
            r_idx   <= w_pick_idx;
            r_addr  <= w_sel_addr;
            r_wdata <= w_sel_wdata;
            r_wr    <= w_sel_wr;
            r_sel   <= 1'b1;
          end
        end
        BUS: begin
          if (w_complete) begin
            // A timed-out read returns nothing, so rdata keeps its old value.
            if (m_ready && !r_wr) begin
              r_rdata <= m_rdata;
            end
            r_sel  <= 1'b0;
            r_wr   <= 1'b0;
            r_done <= r_gnt;
            r_ptr  <= w_ptr_nxt;
          end
        end
        DONE: begin
          r_gnt <= '0;
        end
        default: begin
          r_gnt <= '0;
          r_sel <= 1'b0;
          r_wr  <= 1'b0;
        end
      endcase
    end
  end

  assign gnt     = r_gnt;
  assign done    = r_done;
  assign rdata   = r_rdata;
  assign m_addr  = r_addr;
  assign m_wdata = r_wdata;
  assign m_sel   = r_sel;
  assign m_wr    = r_wr;

endmodule

`default_nettype wire

// File: tb/tb_reg_arbiter.sv
// ============================================================================
// tb_reg_arbiter : directed scoreboard bench for reg_arbiter with a reg_ctrl model
// Revision       : 1.0
// ============================================================================
`default_nettype none

module tb_reg_arbiter;

  localparam int NR  = 4;
  localparam int AW  = 8;
  localparam int DW  = 16;
  localparam int TMO = 8;

  logic             clk = 1'b0;
  logic             rstn = 1'b0;
  logic [NR-1:0]    req = '0;
  logic [NR-1:0]    req_wr = '0;
  logic [NR*AW-1:0] req_addr = '0;
  logic [NR*DW-1:0] req_wdata = '0;
  logic [NR-1:0]    gnt, done;
  logic [DW-1:0]    rdata, m_wdata;
  logic [DW-1:0]    m_rdata = '0;
  logic [AW-1:0]    m_addr;
  logic             err, m_sel, m_wr;
  logic             m_ready = 1'b0;

  reg_arbiter #(
    .NUM_REQ        (NR),
    .ADDR_WIDTH     (AW),
    .DATA_WIDTH     (DW),
    .TIMEOUT_CYCLES (TMO)
  ) dut (
    .clk       (clk),
    .rstn      (rstn),
    .req       (req),
    .req_wr    (req_wr),
    .req_addr  (req_addr),
    .req_wdata (req_wdata),
    .gnt       (gnt),
    .done      (done),
    .rdata     (rdata),
    .err       (err),
    .m_addr    (m_addr),
    .m_wdata   (m_wdata),
    .m_sel     (m_sel),
    .m_wr      (m_wr),
    .m_rdata   (m_rdata),
    .m_ready   (m_ready)
  );

  always #5 clk = ~clk;

  typedef struct {
    int            idx;
    logic [DW-1:0] rdata;
    logic          err;
  } exp_t;

  exp_t          exp_q[$];
  int            checks = 0;
  int            errors = 0;
  int            cyc = 0;
  int            lat = 0;
  int            bus_cnt = 0;
  logic [DW-1:0] last_rdata = '0;
  logic [DW-1:0] mem [256] = '{default: '0};

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    assert (got === exp) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, got, exp);
    end
  endtask

  always @(posedge clk) cyc <= cyc + 1;

  // reg_ctrl model: ready after 'lat' BUS cycles, simple register file.
  always @(negedge clk) begin
    if (m_sel) begin
      m_ready = (bus_cnt == lat);
      m_rdata = mem[m_addr];
      bus_cnt++;
    end else begin
      m_ready = 1'b0;
      bus_cnt = 0;
    end
  end

  always @(posedge clk) begin
    if (m_sel && m_wr && m_ready) mem[m_addr] <= m_wdata;
  end

  // Scoreboard: every done pulse must match the oldest pushed expectation.
  always @(negedge clk) begin
    exp_t e;
    if (rstn && done !== '0) begin
      checks++;
      assert (exp_q.size() > 0) else begin
        errors++;
        $error("FAIL sb_unexpected: observed done=%b expected none", done);
      end
      if (exp_q.size() > 0) begin
        e = exp_q.pop_front();
        chk("sb_done", 32'(done), 32'(1 << e.idx));
        chk("sb_gnt", 32'(gnt), 32'(1 << e.idx));
        chk("sb_rdata", 32'(rdata), 32'(e.rdata));
        chk("sb_err", 32'(err), 32'(e.err));
      end
    end
  end

  task automatic push(input int i, input logic [DW-1:0] rd, input logic e);
    exp_t x;
    x.idx = i; x.rdata = rd; x.err = e;
    exp_q.push_back(x);
  endtask

  task automatic drive(input int i, input logic wr, input logic [AW-1:0] a, input logic [DW-1:0] d);
    req_wr[i]             = wr;
    req_addr[i*AW +: AW]  = a;
    req_wdata[i*DW +: DW] = d;
    req[i]                = 1'b1;
  endtask

  task automatic wait_done(input int i, input bit drop);
    int n;
    n = 0;
    while (done[i] !== 1'b1 && n < 40) begin
      @(negedge clk);
      n++;
    end
    checks++;
    assert (done[i] === 1'b1) else begin
      errors++;
      $error("FAIL wait_done%0d: observed done=%b expected bit %0d within 40 cycles", i, done, i);
    end
    if (drop) req[i] = 1'b0;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: observed no finish expected finish before time limit");
    $fatal(1, "watchdog");
  end

  initial begin
    int c0;
    repeat (2) @(negedge clk);
    chk("rst_gnt", 32'(gnt), 0);
    chk("rst_done", 32'(done), 0);
    chk("rst_err", 32'(err), 0);
    chk("rst_sel", 32'(m_sel), 0);
    chk("rst_wr", 32'(m_wr), 0);
    chk("rst_addr", 32'(m_addr), 0);
    chk("rst_wdata", 32'(m_wdata), 0);
    chk("rst_rdata", 32'(rdata), 0);
    rstn = 1'b1;
    @(negedge clk);

    // Single write from requester 0
    lat = 2;
    drive(0, 1'b1, 8'h04, 16'hBEEF);
    push(0, last_rdata, 1'b0);
    @(negedge clk);
    chk("wr_sel", 32'(m_sel), 1);
    chk("wr_wr", 32'(m_wr), 1);
    chk("wr_addr", 32'(m_addr), 32'h04);
    chk("wr_wdata", 32'(m_wdata), 32'hBEEF);
    chk("wr_gnt", 32'(gnt), 32'b0001);
    @(negedge clk);
    chk("wr_hold_addr", 32'(m_addr), 32'h04);
    wait_done(0, 1'b1);
    chk("wr_done_sel", 32'(m_sel), 0);
    @(negedge clk);
    chk("wr_gnt_clr", 32'(gnt), 0);

    // Single read from requester 2; done is visible after edge N+1+lat
    lat = 2;
    c0 = cyc;
    drive(2, 1'b0, 8'h04, 16'h0000);
    push(2, 16'hBEEF, 1'b0);
    last_rdata = 16'hBEEF;
    wait_done(2, 1'b1);
    chk("rd_latency", 32'(cyc - c0), 32'(lat + 2));
    @(negedge clk);
    chk("rd_hold", 32'(rdata), 32'hBEEF);

    // Fairness from a fresh reset: order 0,1,2,3,0,1
    rstn = 1'b0;
    @(negedge clk);
    rstn = 1'b1;
    last_rdata = '0;
    lat = 0;
    for (int i = 0; i < NR; i++) drive(i, 1'b1, 8'(8'h10 + i), 16'(16'h1000 + i));
    push(0, '0, 1'b0); push(1, '0, 1'b0); push(2, '0, 1'b0);
    push(3, '0, 1'b0); push(0, '0, 1'b0); push(1, '0, 1'b0);
    wait_done(0, 1'b0);
    wait_done(1, 1'b0);
    wait_done(2, 1'b1);
    wait_done(3, 1'b1);
    wait_done(0, 1'b1);
    wait_done(1, 1'b1);
    @(negedge clk);

    // Requester 1 changes address and drops req during BUS
    lat = 3;
    drive(1, 1'b0, 8'h10, 16'h0000);
    push(1, 16'h1000, 1'b0);
    last_rdata = 16'h1000;
    @(negedge clk);
    req_addr[1*AW +: AW] = 8'h20;
    req_wr[1] = 1'b1;
    req[1] = 1'b0;
    @(negedge clk);
    chk("mid_addr", 32'(m_addr), 32'h10);
    chk("mid_wr", 32'(m_wr), 0);
    @(negedge clk);
    chk("mid_addr2", 32'(m_addr), 32'h10);
    wait_done(1, 1'b1);
    @(negedge clk);

    // Asynchronous reset during BUS
    lat = 1000;
    drive(3, 1'b0, 8'h04, 16'h0000);
    @(negedge clk);
    chk("arst_pre_sel", 32'(m_sel), 1);
    #2 rstn = 1'b0;
    #1;
    chk("arst_sel", 32'(m_sel), 0);
    chk("arst_gnt", 32'(gnt), 0);
    chk("arst_done", 32'(done), 0);
    req[3] = 1'b0;
    @(negedge clk);
    rstn = 1'b1;
    last_rdata = '0;
    lat = 0;
    drive(2, 1'b1, 8'h30, 16'h3333);
    drive(0, 1'b1, 8'h31, 16'h4444);
    push(0, '0, 1'b0);
    push(2, '0, 1'b0);
    wait_done(0, 1'b1);
    wait_done(2, 1'b1);
    @(negedge clk);

`ifdef REG_ARB_TIMEOUT_EN
    // Watchdog: no ready, done+err TMO cycles after BUS entry
    lat = 1000;
    drive(0, 1'b0, 8'h04, 16'h0000);
    push(0, last_rdata, 1'b1);
    @(negedge clk);
    c0 = cyc;
    wait_done(0, 1'b1);
    chk("tmo_latency", 32'(cyc - c0), 32'(TMO));
    @(negedge clk);
    chk("tmo_err_clr", 32'(err), 0);
    lat = 0;
    drive(1, 1'b0, 8'h04, 16'h0000);
    push(1, 16'hBEEF, 1'b0);
    last_rdata = 16'hBEEF;
    wait_done(1, 1'b1);
    @(negedge clk);
`endif

    repeat (3) @(negedge clk);
    chk("sb_empty", 32'(exp_q.size()), 0);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

`default_nettype wire
